// File: rtl/mem_arb_pkg.sv
// Shared definitions for the N-channel memory request arbiter.
//   cw_f      : width of the channel field in the memory tag, max(1, clog2(n))
//   tag_t     : {chan, idx} memory tag layout for the default configuration
//   tag_pack  : build a memory tag from a channel number and a client tag
//   tag_chan  : extract the channel number from a memory tag
//   tag_idx   : extract the client tag from a memory tag
// The helpers work on 32-bit containers so that any parameterisation can use
// them; callers size-cast the result to the real tag width.
package mem_arb_pkg;

  function automatic int cw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_N     = 4;
  localparam int DEF_IDX_W = 3;
  localparam int DEF_CW    = cw_f(DEF_N);

  typedef struct packed {
    logic [DEF_CW-1:0]    chan;
    logic [DEF_IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [31:0] tag_pack(input logic [31:0] chan,
                                           input logic [31:0] idx,
                                           input int          idx_w);
    return (chan << idx_w) | (idx & ((32'd1 << idx_w) - 32'd1));
  endfunction

  function automatic logic [31:0] tag_chan(input logic [31:0] tag, input int idx_w);
    return tag >> idx_w;
  endfunction

  function automatic logic [31:0] tag_idx(input logic [31:0] tag, input int idx_w);
    return tag & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_req_arb_if.sv
// Bus bundle between the table-walker clients, the arbiter and the shared
// memory port.
//   req_i_*     : per-channel client requests (flattened, channel c at c*W)
//   res_o_*     : per-channel response valid/ready, shared tag and data
//   mem_req_o_* : registered request toward memory, tag = {chan, idx}
//   mem_res_i_* : memory response carrying the same tag back
// Modports: master = arbiter side, slave = clients/memory environment side.
interface mem_req_arb_if #(
  parameter int N      = 4,
  parameter int IDX_W  = 3,
  parameter int MCN_W  = 52,
  parameter int DATA_W = 512
);
  localparam int CW = mem_arb_pkg::cw_f(N);

  logic [N-1:0]        req_i_valid;
  logic [N-1:0]        req_i_ready;
  logic [N*IDX_W-1:0]  req_i_bits_idx;
  logic [N*MCN_W-1:0]  req_i_bits_mcn;

  logic [N-1:0]        res_o_valid;
  logic [N-1:0]        res_o_ready;
  logic [IDX_W-1:0]    res_o_bits_idx;
  logic [DATA_W-1:0]   res_o_bits_data;

  logic                mem_req_o_valid;
  logic                mem_req_o_ready;
  logic [CW+IDX_W-1:0] mem_req_o_bits_idx;
  logic [MCN_W-1:0]    mem_req_o_bits_mcn;

  logic                mem_res_i_valid;
  logic                mem_res_i_ready;
  logic [CW+IDX_W-1:0] mem_res_i_bits_idx;
  logic [DATA_W-1:0]   mem_res_i_bits_data;

  modport master (
    input  req_i_valid, req_i_bits_idx, req_i_bits_mcn, res_o_ready,
           mem_req_o_ready, mem_res_i_valid, mem_res_i_bits_idx, mem_res_i_bits_data,
    output req_i_ready, res_o_valid, res_o_bits_idx, res_o_bits_data,
           mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn, mem_res_i_ready
  );

  modport slave (
    output req_i_valid, req_i_bits_idx, req_i_bits_mcn, res_o_ready,
           mem_req_o_ready, mem_res_i_valid, mem_res_i_bits_idx, mem_res_i_bits_data,
    input  req_i_ready, res_o_valid, res_o_bits_idx, res_o_bits_data,
           mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_mcn, mem_res_i_ready
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker.
//   elig  : in  N  channels allowed to win this cycle
//   ptr   : in  CW last granted channel (owned by the parent)
//   grant : out N  one-hot winner, first eligible channel after ptr (wrapping)
module mem_arb_rr #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    // Walk distances 1..N from ptr so that ptr itself is considered last.
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && elig[j] && (j == ((int'(ptr) + i) % N))) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_req_arb.sv
// N-channel arbiter between table-walker clients and the single memory port.
// Round-robin grant, per-channel outstanding limit of OUTS, a one-entry
// registered request toward memory and combinational tag-routed responses.
//   clock  : in  clock
//   reset  : in  asynchronous active-low reset
//   bus    : mem_req_arb_if.master, client and memory handshakes
//   err_o  : out sticky spurious-response flag
// Optional feature: define MEM_REQ_ARB_ERR_EN to build spurious-response
// detection (response to a channel with nothing outstanding, or to a channel
// number >= N). Without it err_o is tied low.
module mem_req_arb
  import mem_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int IDX_W  = 3,
  parameter int MCN_W  = 52,
  parameter int DATA_W = 512,
  parameter int OUTS   = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_req_arb_if.master bus,
  output logic          err_o
);

  localparam int CW    = cw_f(N);
  localparam int CNT_W = $clog2(OUTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N-1:0]       elig;
  logic [N-1:0]       grant;
  logic [N-1:0]       rdy;
  logic [N-1:0]       dec;
  logic [N-1:0]       res_vld;
  logic               mres_rdy;
  logic [CW-1:0]      ptr;
  logic [CW-1:0]      gchan;
  logic [IDX_W-1:0]   sel_idx;
  logic [MCN_W-1:0]   sel_mcn;
  logic               load_ok;
  logic               req_hs;
  logic [31:0]        rchan_w;
  logic [CNT_W-1:0]   cnt [N];

  logic               vld_p1;
  logic [CW-1:0]      chan_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [MCN_W-1:0]   mcn_p1;

  always_comb begin
    elig = '0;
    for (int c = 0; c < N; c++) begin
      elig[c] = bus.req_i_valid[c] && (cnt[c] < CNT_W'(OUTS));
    end
  end

  mem_arb_rr #(.N(N), .CW(CW)) u_rr (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant)
  );

  // The output slot can take a new request when empty or draining this cycle.
  assign load_ok = ~vld_p1 | bus.mem_req_o_ready;
  assign rdy     = grant & {N{load_ok & reset}};
  assign req_hs  = |rdy;
  assign bus.req_i_ready = rdy;

  always_comb begin
    gchan   = '0;
    sel_idx = '0;
    sel_mcn = '0;
    for (int c = 0; c < N; c++) begin
      if (grant[c]) begin
        gchan   = CW'(c);
        sel_idx = bus.req_i_bits_idx[c*IDX_W +: IDX_W];
        sel_mcn = bus.req_i_bits_mcn[c*MCN_W +: MCN_W];
      end
    end
  end

  // ---- stage p1: registered memory request (control) ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      ptr    <= CW'(N - 1);
    end else begin
      if (load_ok) vld_p1 <= req_hs;
      if (req_hs)  ptr    <= gchan;
    end
  end

  // ---- stage p1: registered memory request (data) ----
  always_ff @(posedge clock) begin
    if (req_hs) begin
      chan_p1 <= gchan;
      idx_p1  <= sel_idx;
      mcn_p1  <= sel_mcn;
    end
  end

  assign bus.mem_req_o_valid    = vld_p1;
  assign bus.mem_req_o_bits_idx = (CW+IDX_W)'(tag_pack(32'(chan_p1), 32'(idx_p1), IDX_W));
  assign bus.mem_req_o_bits_mcn = mcn_p1;

  // Response routing: the channel field of the tag selects the client.
  // Tags naming a channel >= N match no client and are accepted and dropped.
  assign rchan_w = tag_chan(32'(bus.mem_res_i_bits_idx), IDX_W);

  always_comb begin
    res_vld  = '0;
    mres_rdy = 1'b1;
    dec      = '0;
    for (int c = 0; c < N; c++) begin
      if (rchan_w == 32'(c)) begin
        res_vld[c] = bus.mem_res_i_valid;
        mres_rdy   = bus.res_o_ready[c];
        dec[c]     = bus.mem_res_i_valid & bus.res_o_ready[c];
      end
    end
  end

  assign bus.res_o_valid     = res_vld;
  assign bus.mem_res_i_ready = mres_rdy;
  assign bus.res_o_bits_idx  = IDX_W'(tag_idx(32'(bus.mem_res_i_bits_idx), IDX_W));
  assign bus.res_o_bits_data = bus.mem_res_i_bits_data;

  // ---- stage p1: outstanding counters ----
  // Grant and response in the same cycle cancel; both directions saturate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (rdy[c] && !dec[c] && (cnt[c] != CNT_MAX)) begin
          cnt[c] <= cnt[c] + 1'b1;
        end else if (dec[c] && !rdy[c] && (cnt[c] != '0)) begin
          cnt[c] <= cnt[c] - 1'b1;
        end
      end
    end
  end

`ifdef MEM_REQ_ARB_ERR_EN
  logic res_hs;
  logic in_range;
  logic spurious;
  logic err_q;

  assign res_hs   = bus.mem_res_i_valid & mres_rdy;
  assign in_range = rchan_w < 32'(N);

  always_comb begin
    spurious = res_hs && !in_range;
    for (int c = 0; c < N; c++) begin
      if ((rchan_w == 32'(c)) && (cnt[c] == '0)) spurious = res_hs;
    end
  end

  // ---- stage p1: sticky error flag ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        err_q <= 1'b0;
    else if (spurious) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
`timescale 1ns/1ps
module tb_mem_req_arb;
  import mem_arb_pkg::*;

  localparam int N      = 4;
  localparam int IDX_W  = 3;
  localparam int MCN_W  = 52;
  localparam int DATA_W = 512;
  localparam int OUTS   = 4;
  localparam int CW     = 2;
  localparam int TW     = CW + IDX_W;
`ifdef MEM_REQ_ARB_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic err_o;
  int   checks   = 0;
  int   failures = 0;

  mem_req_arb_if #(.N(N), .IDX_W(IDX_W), .MCN_W(MCN_W), .DATA_W(DATA_W)) bus ();

  mem_req_arb #(.N(N), .IDX_W(IDX_W), .MCN_W(MCN_W), .DATA_W(DATA_W), .OUTS(OUTS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .err_o (err_o)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req_i_valid         = '0;
    bus.req_i_bits_idx      = '0;
    bus.req_i_bits_mcn      = '0;
    bus.res_o_ready         = '1;
    bus.mem_req_o_ready     = 1'b1;
    bus.mem_res_i_valid     = 1'b0;
    bus.mem_res_i_bits_idx  = '0;
    bus.mem_res_i_bits_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_req(input int c, input logic [IDX_W-1:0] idx, input logic [MCN_W-1:0] mcn);
    bus.req_i_valid[c] = 1'b1;
    bus.req_i_bits_idx[c*IDX_W +: IDX_W] = idx;
    bus.req_i_bits_mcn[c*MCN_W +: MCN_W] = mcn;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    idle();
    bus.req_i_valid        = '1;
    bus.mem_res_i_valid    = 1'b1;
    bus.mem_res_i_bits_idx = 5'b01_011;
    #1;
    checks++; if (bus.req_i_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_i_ready); end
    checks++; if (bus.mem_req_o_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_valid got=%b exp=0", bus.mem_req_o_valid); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    checks++; if (bus.res_o_valid !== 4'b0010) begin failures++; $display("FAIL rst_res_valid got=%b exp=0010", bus.res_o_valid); end
    checks++; if (bus.res_o_bits_idx !== 3'd3) begin failures++; $display("FAIL rst_res_idx got=%0d exp=3", bus.res_o_bits_idx); end
    tick();
    tick();
    bus.mem_res_i_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.req_i_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", bus.req_i_ready); end
    idle();
    tick();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d;
    do_reset();
    set_req(2, 3'd5, 52'h1234);
    #1;
    checks++; if (bus.req_i_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", bus.req_i_ready); end
    tick();
    bus.req_i_valid = '0;
    checks++; if (bus.mem_req_o_valid !== 1'b1) begin failures++; $display("FAIL single_mem_valid got=%b exp=1", bus.mem_req_o_valid); end
    checks++; if (bus.mem_req_o_bits_idx !== 5'b10_101) begin failures++; $display("FAIL single_mem_tag got=%b exp=10101", bus.mem_req_o_bits_idx); end
    checks++; if (bus.mem_req_o_bits_mcn !== 52'h1234) begin failures++; $display("FAIL single_mem_mcn got=%h exp=1234", bus.mem_req_o_bits_mcn); end
    for (int w = 0; w < DATA_W/32; w++) d[w*32 +: 32] = $urandom;
    bus.mem_res_i_valid     = 1'b1;
    bus.mem_res_i_bits_idx  = 5'b10_101;
    bus.mem_res_i_bits_data = d;
    #1;
    checks++; if (bus.res_o_valid !== 4'b0100) begin failures++; $display("FAIL single_res_valid got=%b exp=0100", bus.res_o_valid); end
    checks++; if (bus.res_o_bits_idx !== 3'd5) begin failures++; $display("FAIL single_res_idx got=%0d exp=5", bus.res_o_bits_idx); end
    checks++; if (bus.res_o_bits_data !== d) begin failures++; $display("FAIL single_res_data got=%h exp=%h", bus.res_o_bits_data[63:0], d[63:0]); end
    checks++; if (bus.mem_res_i_ready !== 1'b1) begin failures++; $display("FAIL single_mem_res_ready got=%b exp=1", bus.mem_res_i_ready); end
    bus.res_o_ready = 4'b1011;
    #1;
    checks++; if (bus.mem_res_i_ready !== 1'b0) begin failures++; $display("FAIL single_res_backpressure got=%b exp=0", bus.mem_res_i_ready); end
    tick();
    idle();
  endtask

  task automatic test_rr();
    logic [N-1:0] exp;
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, IDX_W'(c + 1), MCN_W'(c * 16));
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = '0;
      exp[k % N] = 1'b1;
      checks++; if (bus.req_i_ready !== exp) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, bus.req_i_ready, exp); end
      if (k > 0) begin
        checks++;
        if (bus.mem_req_o_bits_idx[TW-1 -: CW] !== CW'((k - 1) % N)) begin
          failures++; $display("FAIL rr_mem_chan k=%0d got=%0d exp=%0d", k, bus.mem_req_o_bits_idx[TW-1 -: CW], (k - 1) % N);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_outs_limit();
    do_reset();
    set_req(1, 3'd2, 52'hABC);
    for (int k = 0; k < OUTS; k++) begin
      #1;
      checks++; if (bus.req_i_ready !== 4'b0010) begin failures++; $display("FAIL outs_accept k=%0d got=%b exp=0010", k, bus.req_i_ready); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.req_i_ready !== 4'b0000) begin failures++; $display("FAIL outs_full k=%0d got=%b exp=0000", k, bus.req_i_ready); end
      tick();
    end
    bus.mem_res_i_valid    = 1'b1;
    bus.mem_res_i_bits_idx = 5'b01_000;
    #1;
    checks++; if (bus.req_i_ready !== 4'b0000) begin failures++; $display("FAIL outs_resp_cycle got=%b exp=0000", bus.req_i_ready); end
    tick();
    bus.mem_res_i_valid = 1'b0;
    #1;
    checks++; if (bus.req_i_ready !== 4'b0010) begin failures++; $display("FAIL outs_reopen got=%b exp=0010", bus.req_i_ready); end
    tick();
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 3'd1, 52'h0_AAAA_5555_1111);
    #1;
    checks++; if (bus.req_i_ready !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", bus.req_i_ready); end
    tick();
    bus.req_i_valid     = '0;
    bus.mem_req_o_ready = 1'b0;
    set_req(3, 3'd6, 52'hF_0000_BEEF_0003);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.req_i_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, bus.req_i_ready); end
      checks++; if (bus.mem_req_o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, bus.mem_req_o_valid); end
      checks++; if (bus.mem_req_o_bits_idx !== 5'b00_001) begin failures++; $display("FAIL bp_tag k=%0d got=%b exp=00001", k, bus.mem_req_o_bits_idx); end
      checks++; if (bus.mem_req_o_bits_mcn !== 52'h0_AAAA_5555_1111) begin failures++; $display("FAIL bp_mcn k=%0d got=%h", k, bus.mem_req_o_bits_mcn); end
      tick();
    end
    bus.mem_req_o_ready = 1'b1;
    #1;
    checks++; if (bus.req_i_ready !== 4'b1000) begin failures++; $display("FAIL bp_drain_grant got=%b exp=1000", bus.req_i_ready); end
    tick();
    bus.req_i_valid = '0;
    checks++; if (bus.mem_req_o_bits_idx !== 5'b11_110) begin failures++; $display("FAIL bp_new_tag got=%b exp=11110", bus.mem_req_o_bits_idx); end
    checks++; if (bus.mem_req_o_bits_mcn !== 52'hF_0000_BEEF_0003) begin failures++; $display("FAIL bp_new_mcn got=%h", bus.mem_req_o_bits_mcn); end
    idle();
    tick();
  endtask

  task automatic test_same_cycle();
    int acc;
    do_reset();
    set_req(0, 3'd4, 52'h77);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.req_i_ready !== 4'b0001) begin failures++; $display("FAIL same_pre k=%0d got=%b exp=0001", k, bus.req_i_ready); end
      tick();
    end
    bus.mem_res_i_valid    = 1'b1;
    bus.mem_res_i_bits_idx = 5'b00_100;
    #1;
    checks++; if (bus.req_i_ready !== 4'b0001) begin failures++; $display("FAIL same_grant got=%b exp=0001", bus.req_i_ready); end
    tick();
    bus.mem_res_i_valid = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.req_i_ready[0]) acc++;
      tick();
    end
    checks++; if (acc !== 2) begin failures++; $display("FAIL same_cnt_kept accepted=%0d exp=2", acc); end
    idle();
  endtask

  task automatic test_reset_mid();
    int acc;
    do_reset();
    bus.mem_req_o_ready = 1'b0;
    set_req(1, 3'd7, 52'h55);
    tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.mem_req_o_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.mem_req_o_valid); end
    checks++; if (bus.req_i_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.req_i_ready); end
    tick();
    reset = 1'b1;
    bus.mem_req_o_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < OUTS + 1; k++) begin
      #1;
      if (bus.req_i_ready[1]) acc++;
      tick();
    end
    checks++; if (acc !== OUTS) begin failures++; $display("FAIL mid_rst_cnt_cleared accepted=%0d exp=%0d", acc, OUTS); end
    idle();
  endtask

  task automatic test_err();
    do_reset();
    bus.mem_res_i_valid    = 1'b1;
    bus.mem_res_i_bits_idx = 5'b11_000;
    #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_before got=%b exp=0", err_o); end
    checks++; if (bus.mem_res_i_ready !== 1'b1) begin failures++; $display("FAIL err_res_ready got=%b exp=1", bus.mem_res_i_ready); end
    tick();
    bus.mem_res_i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (err_o !== ERR_EN) begin failures++; $display("FAIL err_sticky k=%0d got=%b exp=%b", k, err_o, ERR_EN); end
      tick();
    end
    reset = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_reset got=%b exp=0", err_o); end
    tick();
    reset = 1'b1;
    idle();
  endtask

  task automatic test_random();
    int               m_cnt [N];
    int               m_ptr;
    logic             m_vld;
    logic [TW-1:0]    m_tag;
    logic [MCN_W-1:0] m_mcn;
    logic             m_err;
    logic [IDX_W-1:0] ridx [N];
    logic [MCN_W-1:0] rmcn [N];
    logic [DATA_W-1:0] d;
    logic [N-1:0]     exp_rdy, exp_rv;
    logic             exp_mr, load_ok, rv, rhs;
    int               g, rc, ri, c;
    int               cand [$];

    do_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = N - 1;
    m_vld = 1'b0;
    m_tag = '0;
    m_mcn = '0;
    m_err = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.req_i_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ridx[i] = IDX_W'($urandom);
        rmcn[i] = {20'($urandom), $urandom};
        bus.req_i_bits_idx[i*IDX_W +: IDX_W] = ridx[i];
        bus.req_i_bits_mcn[i*MCN_W +: MCN_W] = rmcn[i];
      end
      bus.mem_req_o_ready = ($urandom_range(0, 3) != 0);
      bus.res_o_ready     = N'($urandom) | N'($urandom);
      rv = ($urandom_range(0, 1) == 1);
      cand.delete();
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) < 8) rc = cand[$urandom_range(0, cand.size() - 1)];
      else rc = $urandom_range(0, N - 1);
      ri = $urandom_range(0, (1 << IDX_W) - 1);
      for (int w = 0; w < DATA_W/32; w++) d[w*32 +: 32] = $urandom;
      bus.mem_res_i_valid     = rv;
      bus.mem_res_i_bits_idx  = TW'((rc << IDX_W) | ri);
      bus.mem_res_i_bits_data = d;
      #1;

      load_ok = !m_vld || bus.mem_req_o_ready;
      g = -1;
      for (int i = 1; i <= N; i++) begin
        c = (m_ptr + i) % N;
        if (g < 0 && bus.req_i_valid[c] && m_cnt[c] < OUTS) g = c;
      end
      exp_rdy = '0;
      if (load_ok && g >= 0) exp_rdy[g] = 1'b1;
      exp_rv = '0;
      exp_rv[rc] = rv;
      exp_mr = bus.res_o_ready[rc];

      checks++; if (bus.req_i_ready !== exp_rdy) begin failures++; $display("FAIL rnd_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_i_ready, exp_rdy); end
      checks++; if (bus.mem_req_o_valid !== m_vld) begin failures++; $display("FAIL rnd_mem_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_req_o_valid, m_vld); end
      if (m_vld) begin
        checks++; if (bus.mem_req_o_bits_idx !== m_tag) begin failures++; $display("FAIL rnd_mem_tag cyc=%0d got=%b exp=%b", cyc, bus.mem_req_o_bits_idx, m_tag); end
        checks++; if (bus.mem_req_o_bits_mcn !== m_mcn) begin failures++; $display("FAIL rnd_mem_mcn cyc=%0d got=%h exp=%h", cyc, bus.mem_req_o_bits_mcn, m_mcn); end
      end
      checks++; if (bus.res_o_valid !== exp_rv) begin failures++; $display("FAIL rnd_res_valid cyc=%0d got=%b exp=%b", cyc, bus.res_o_valid, exp_rv); end
      checks++; if (bus.mem_res_i_ready !== exp_mr) begin failures++; $display("FAIL rnd_mem_res_ready cyc=%0d got=%b exp=%b", cyc, bus.mem_res_i_ready, exp_mr); end
      checks++; if (bus.res_o_bits_idx !== IDX_W'(ri)) begin failures++; $display("FAIL rnd_res_idx cyc=%0d got=%0d exp=%0d", cyc, bus.res_o_bits_idx, ri); end
      checks++; if (bus.res_o_bits_data !== d) begin failures++; $display("FAIL rnd_res_data cyc=%0d got=%h exp=%h", cyc, bus.res_o_bits_data[63:0], d[63:0]); end
      checks++; if (err_o !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_o, m_err); end

      rhs = rv && exp_mr;
      if (rhs && m_cnt[rc] == 0 && ERR_EN) m_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (load_ok && g == i && !(rhs && rc == i)) m_cnt[i]++;
        else if (rhs && rc == i && !(load_ok && g == i) && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (load_ok) m_vld = (g >= 0);
      if (load_ok && g >= 0) begin
        m_tag = TW'((g << IDX_W) | int'(ridx[g]));
        m_mcn = rmcn[g];
        m_ptr = g;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_rr();
    test_outs_limit();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
